// File: rtl/coin_pkg.sv
// Shared types and constants for the coin parser / dispenser pair.
package coin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } disp_state_t;

  localparam logic [3:0] COIN_BLANK = 4'd10;

  localparam int unsigned COIN_VAL_Q = 25;
  localparam int unsigned COIN_VAL_D = 10;
  localparam int unsigned COIN_VAL_N = 5;

  // Parser blank sentinel and any out-of-range digit collapse to zero coins.
  function automatic logic [3:0] sanitize_count(input logic [3:0] raw);
    return (raw >= COIN_BLANK) ? 4'd0 : raw;
  endfunction

endpackage

// File: rtl/coin_timer.sv
// Loadable down-counter with hold enable; zero flag is registered alongside the count.
module coin_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q, zero_d;

  // Load wins over count; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
    zero_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/coin_dispenser.sv
// Drives the quarter/dime/nickel solenoids one coin at a time, largest denomination first.
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] q_in,
  input  logic [3:0] d_in,
  input  logic [3:0] n_in,
  input  logic       pause,
  output logic       coin_q,
  output logic       coin_d,
  output logic       coin_n,
  output logic [3:0] q_left,
  output logic [3:0] d_left,
  output logic [3:0] n_left,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TW      = (MAX_CYC + 1 > 2) ? $clog2(MAX_CYC + 1) : 1;

  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  disp_state_t   state_q, state_d;
  logic [3:0]    q_left_q, q_left_d;
  logic [3:0]    d_left_q, d_left_d;
  logic [3:0]    n_left_q, n_left_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_en;
  logic          tmr_zero;

  logic [3:0]    q_san, d_san, n_san;
  logic          sel_q, sel_d, sel_n;
  logic          any_left;

  assign q_san = sanitize_count(q_in);
  assign d_san = sanitize_count(d_in);
  assign n_san = sanitize_count(n_in);

  // Priority pick from registered counts; nickel is the fallback when nothing else remains.
  assign sel_q    = (q_left_q != 4'd0);
  assign sel_d    = !sel_q && (d_left_q != 4'd0);
  assign sel_n    = !sel_q && !sel_d;
  assign any_left = (q_left_q != 4'd0) || (d_left_q != 4'd0) || (n_left_q != 4'd0);

  coin_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // Next-state, count and timer control.
  always_comb begin
    state_d  = state_q;
    q_left_d = q_left_q;
    d_left_d = d_left_q;
    n_left_d = n_left_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_left_d = q_san;
          d_left_d = d_san;
          n_left_d = n_san;
          if ((q_san != 4'd0) || (d_san != 4'd0) || (n_san != 4'd0)) begin
            state_d  = ST_PULSE;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_PULSE: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          if (sel_q) begin
            q_left_d = q_left_q - 4'd1;
          end else if (sel_d) begin
            d_left_d = d_left_q - 4'd1;
          end else begin
            n_left_d = n_left_q - 4'd1;
          end
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end

      ST_GAP: begin
        if (!pause) begin
          if (tmr_zero) begin
            if (any_left) begin
              state_d  = ST_PULSE;
              tmr_load = 1'b1;
              tmr_val  = PULSE_LOAD;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      q_left_q <= 4'd0;
      d_left_q <= 4'd0;
      n_left_q <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_left_q <= q_left_d;
      d_left_q <= d_left_d;
      n_left_q <= n_left_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Solenoids decode from registered state and counts only, so they cannot glitch.
  always_comb begin
    coin_q = 1'b0;
    coin_d = 1'b0;
    coin_n = 1'b0;
    if (state_q == ST_PULSE) begin
      coin_q = sel_q;
      coin_d = sel_d;
      coin_n = sel_n;
    end
  end

  assign q_left = q_left_q;
  assign d_left = d_left_q;
  assign n_left = n_left_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Randomized self-checking bench for coin_dispenser against a coin-timeline reference model.
module tb_coin_dispenser;

  localparam int unsigned P    = 4;
  localparam int unsigned G    = 4;
  localparam int          MAXC = 2048;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] q_in, d_in, n_in;
  logic       pause;
  logic       coin_q, coin_d, coin_n;
  logic [3:0] q_left, d_left, n_left;
  logic       busy, done;

  int n_checks = 0;
  int n_errors = 0;

  bit         pz       [MAXC];
  logic [2:0] exp_coin [MAXC];
  logic [3:0] exp_ql   [MAXC];
  logic [3:0] exp_dl   [MAXC];
  logic [3:0] exp_nl   [MAXC];
  bit         exp_busy [MAXC];
  bit         exp_done [MAXC];
  int         done_cyc;

  always #5 clk = ~clk;

  coin_dispenser #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .q_in    (q_in),
    .d_in    (d_in),
    .n_in    (n_in),
    .pause   (pause),
    .coin_q  (coin_q),
    .coin_d  (coin_d),
    .coin_n  (coin_n),
    .q_left  (q_left),
    .d_left  (d_left),
    .n_left  (n_left),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs: each coin is P pulse cycles, then a gap lasting until G unpaused cycles elapse.
  task automatic build_model(input logic [3:0] qi, input logic [3:0] di, input logic [3:0] ni);
    int         qq, dd, nn, c, unp;
    logic [2:0] sel;
    qq = (qi >= 4'd10) ? 0 : int'(qi);
    dd = (di >= 4'd10) ? 0 : int'(di);
    nn = (ni >= 4'd10) ? 0 : int'(ni);
    for (int i = 0; i < MAXC; i++) begin
      exp_coin[i] = 3'b000;
      exp_ql[i]   = 4'd0;
      exp_dl[i]   = 4'd0;
      exp_nl[i]   = 4'd0;
      exp_busy[i] = 1'b0;
      exp_done[i] = 1'b0;
    end
    c = 1;
    while ((qq + dd + nn) > 0 && c < MAXC - 64) begin
      sel = (qq > 0) ? 3'b100 : ((dd > 0) ? 3'b010 : 3'b001);
      for (int p = 0; p < int'(P); p++) begin
        exp_coin[c] = sel;
        exp_ql[c] = 4'(qq); exp_dl[c] = 4'(dd); exp_nl[c] = 4'(nn);
        exp_busy[c] = 1'b1;
        c++;
      end
      if (sel == 3'b100) qq--;
      else if (sel == 3'b010) dd--;
      else nn--;
      unp = 0;
      while (unp < int'(G) && c < MAXC - 64) begin
        exp_ql[c] = 4'(qq); exp_dl[c] = 4'(dd); exp_nl[c] = 4'(nn);
        exp_busy[c] = 1'b1;
        if (!pz[c]) unp++;
        c++;
      end
    end
    exp_busy[c] = 1'b1;
    exp_done[c] = 1'b1;
    done_cyc = c;
  endtask

  task automatic run_txn(input logic [3:0] qi, input logic [3:0] di, input logic [3:0] ni,
                         input int exp_done_lit, input bit rand_pause);
    int obs_done;
    if (rand_pause) begin
      for (int i = 0; i < MAXC; i++) pz[i] = ($urandom_range(0, 3) == 0);
    end
    pz[0] = 1'b0;
    build_model(qi, di, ni);
    obs_done = 0;
    pause = 1'b0;
    start = 1'b1;
    q_in = qi; d_in = di; n_in = ni;
    @(posedge clk);
    for (int c = 1; c <= done_cyc + 1; c++) begin
      #1;
      pause = pz[c];
      if (c <= done_cyc) begin
        start = 1'($urandom_range(0, 1));
        q_in  = 4'($urandom);
        d_in  = 4'($urandom);
        n_in  = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("coin@%0d", c),   32'({coin_q, coin_d, coin_n}), 32'(exp_coin[c]));
      chk($sformatf("q_left@%0d", c), 32'(q_left), 32'(exp_ql[c]));
      chk($sformatf("d_left@%0d", c), 32'(d_left), 32'(exp_dl[c]));
      chk($sformatf("n_left@%0d", c), 32'(n_left), 32'(exp_nl[c]));
      chk($sformatf("busy@%0d", c),   32'(busy),   32'(exp_busy[c]));
      chk($sformatf("done@%0d", c),   32'(done),   32'(exp_done[c]));
      if (done && obs_done == 0) obs_done = c;
      if (c != done_cyc + 1) @(posedge clk);
    end
    if (exp_done_lit > 0) chk("done_cycle", 32'(obs_done), 32'(exp_done_lit));
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    q_in    = 4'd10;
    d_in    = 4'd10;
    n_in    = 4'd10;
    pause   = 1'b0;
    for (int i = 0; i < MAXC; i++) pz[i] = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_coin",   32'({coin_q, coin_d, coin_n}), 32'd0);
    chk("rst_q_left", 32'(q_left), 32'd0);
    chk("rst_d_left", 32'(d_left), 32'd0);
    chk("rst_n_left", 32'(n_left), 32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    run_txn(4'd2, 4'd1, 4'd1, 33, 1'b0);
    run_txn(4'd0, 4'd0, 4'd0, 1, 1'b0);
    run_txn(4'd10, 4'd0, 4'd1, 9, 1'b0);

    for (int i = 1; i <= 4; i++) pz[i] = 1'b1;
    for (int i = 6; i <= 10; i++) pz[i] = 1'b1;
    run_txn(4'd1, 4'd0, 4'd0, 14, 1'b0);
    for (int i = 0; i < MAXC; i++) pz[i] = 1'b0;

    // Abort mid-quarter: solenoid and counts must drop without waiting for a clock edge.
    pause = 1'b0;
    start = 1'b1;
    q_in = 4'd2; d_in = 4'd0; n_in = 4'd0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_pre_coin_q", 32'(coin_q), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_coin",   32'({coin_q, coin_d, coin_n}), 32'd0);
    chk("abort_q_left", 32'(q_left), 32'd0);
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_done",   32'(done),   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_abort_busy", 32'(busy), 32'd0);
    run_txn(4'd1, 4'd0, 4'd0, 9, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/coin_dispenser.md
# coin_dispenser

Change-dispensing stage downstream of the coin parser. Takes the parsed quarter/dime/nickel counts, then drives the three hopper solenoids one coin at a time: quarters first, then dimes, then nickels. Each coin is a fixed-width pulse followed by a fixed gap. Remaining counts are exposed for the seven-segment display, and a one-cycle `done` marks completion.

## Interface
Parameters:
- `PULSE_CYCLES`, 4: solenoid high time per coin, in clk cycles (≥1).
- `GAP_CYCLES`, 4: low time after each coin, in clk cycles (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  load request; sampled only in IDLE.
- `q_in`  in  4  quarters to dispense.
- `d_in`  in  4  dimes to dispense.
- `n_in`  in  4  nickels to dispense.
- `pause`  in  1  hopper-jam hold; freezes the gap timer.
- `coin_q`  out  1  quarter solenoid.
- `coin_d`  out  1  dime solenoid.
- `coin_n`  out  1  nickel solenoid.
- `q_left`  out  4  quarters still to dispense.
- `d_left`  out  4  dimes still to dispense.
- `n_left`  out  4  nickels still to dispense.
- `busy`  out  1  high in PULSE, GAP and DONE.
- `done`  out  1  one-cycle completion strobe.

## Operation
- States: IDLE, PULSE, GAP, DONE.
- Reset forces state IDLE, timer 0, and every output 0, including `*_left`.
- Input sanitising: any `*_in` value ≥ 10 is treated as 0. The value 10 is the parser's blank sentinel and appears on its outputs after reset.
- IDLE, `start`=1:
  - Load the sanitised counts into `*_left`.
  - Any count nonzero → PULSE with timer = PULSE_CYCLES−1.
  - All counts zero → DONE. No coin pulse is issued.
- Coin selection is combinational from `*_left`: quarter if `q_left`≠0, else dime if `d_left`≠0, else nickel. Exactly one `coin_*` is high in PULSE, none in any other state.
- PULSE:
  - Timer counts down each cycle.
  - At timer 0: decrement the selected `*_left` and go to GAP with timer = GAP_CYCLES−1.
  - `pause` has no effect; a started pulse always completes.
- GAP:
  - Timer counts down only while `pause`=0 and holds while `pause`=1.
  - At timer 0 with `pause`=0: any `*_left` nonzero → PULSE, else → DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- `start` outside IDLE is ignored. `*_in` is sampled only on the accepted `start` cycle; later changes have no effect.
- Asserting `reset_n` low mid-dispense aborts immediately. Any solenoid output drops asynchronously and all counts clear.

## Timing
- An accepted `start` at edge 0 puts the first coin high on cycles 1..PULSE_CYCLES.
- Per coin: PULSE_CYCLES + GAP_CYCLES cycles, plus any cycles held by `pause` in GAP.
- Total for k≥1 coins: `done` is high in cycle k·(PULSE_CYCLES+GAP_CYCLES)+1 after start, with no pause.
- Zero-coin start: `done` is high in cycle 1.
- `*_left` updates on the edge that ends each pulse, so the display shows the post-coin count during GAP.
- `busy` falls on the edge after `done`. A new `start` is accepted in that first IDLE cycle.
- Counts are 4-bit, 0..9 per denomination after sanitising. Decrement never underflows because a zero count is never selected.

## Structure
- Shared package `coin_pkg`:
  - `disp_state_t` enum (IDLE, PULSE, GAP, DONE).
  - `COIN_BLANK` = 4'd10.
  - Coin-value constants 25/10/5 for the parser and bench.
- One sub-module, `coin_timer`:
  - Loadable down-counter with load value, enable (hold) and a zero flag.
  - Width is `$clog2` of max(PULSE_CYCLES, GAP_CYCLES)+1.
  - Asynchronous active-low reset.
- All outputs are registered except `coin_*`. Those are decoded from state plus the registered `*_left`, and are glitch-free because all their inputs are registered.

## Test plan
- Reset, then `start` with q=2, d=1, n=1 (P=4, G=4) → pulses in order Q,Q,D,N with `coin_q` high on cycles 1–4 and 9–12; `done` in cycle 33; `*_left` end at 0.
- `start` with q=d=n=0 → no coin pulse; `done` in cycle 1; `busy` high only in cycle 1.
- `start` with q_in=10 (blank), d=0, n=1 → `q_left` loads 0; only one `coin_n` pulse; `done` in cycle 9.
- q=1, `pause` held 5 cycles starting in cycle 6 (inside GAP) → `done` moves from cycle 9 to cycle 14; `pause` asserted during cycles 1–4 leaves the pulse width at 4.
- `start` pulsed again during PULSE with different inputs → ignored; the original sequence is unchanged.
- `reset_n` low in cycle 2 of a quarter pulse → `coin_q` is 0 immediately and `*_left`/`busy` read 0; after release, a fresh `start` with q=1 dispenses normally.
